// File: rtl/multi_chan_trig_pkg.sv
// Shared constants and FSM state type for the multi-channel trigger.
package multi_chan_trig_pkg;

  localparam int unsigned CFG_W   = 5;
  localparam int unsigned CFG_POS = 4;
  localparam int unsigned CFG_NEG = 3;
  localparam int unsigned CFG_HI  = 2;
  localparam int unsigned CFG_LO  = 1;
  localparam int unsigned CFG_DC  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_QUAL = 2'd2,
    ST_TRIG = 2'd3
  } state_t;

endpackage

// File: rtl/multi_chan_trig_ch_slice.sv
// One trigger channel: two-stage sampling, sticky edge hits, level capture, match.
module trig_ch_slice
  import multi_chan_trig_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             armed,
  input  logic             valid,
  input  logic             clr,
  input  logic             ch_h,
  input  logic             ch_l,
  input  logic [CFG_W-1:0] cfg,
  output logic             ch_match_c
);

  logic s_h, s_l, s_h_d, s_l_d;
  logic pos_hit, neg_hit, hi_lvl, lo_lvl;

  // Until the first sample lands, the delayed stage copies the live input so
  // the reset value can never look like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_h     <= 1'b0;
      s_l     <= 1'b0;
      s_h_d   <= 1'b0;
      s_l_d   <= 1'b0;
      pos_hit <= 1'b0;
      neg_hit <= 1'b0;
      hi_lvl  <= 1'b0;
      lo_lvl  <= 1'b0;
    end else begin
      s_h    <= ch_h;
      s_l    <= ch_l;
      s_h_d  <= valid ? s_h : ch_h;
      s_l_d  <= valid ? s_l : ch_l;
      hi_lvl <= valid & s_h;
      lo_lvl <= valid & ~s_l;
      if (clr) begin
        pos_hit <= 1'b0;
        neg_hit <= 1'b0;
      end else begin
        pos_hit <= pos_hit | (armed & valid & ~s_h_d & s_h);
        neg_hit <= neg_hit | (armed & valid & s_l_d & ~s_l);
      end
    end
  end

  assign ch_match_c = (pos_hit & cfg[CFG_POS]) | (neg_hit & cfg[CFG_NEG]) |
                      (hi_lvl & cfg[CFG_HI]) | (lo_lvl & cfg[CFG_LO]) |
                      cfg[CFG_DC];

endmodule

// File: rtl/multi_chan_trig.sv
// Multi-channel AND trigger with optional match qualification.
// Qualification (QUAL state and counter) is built only with MULTI_CHAN_TRIG_QUAL_EN.
module multi_chan_trig
  import multi_chan_trig_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned QUAL_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    armed,
  input  logic [NUM_CH-1:0]       ch_h,
  input  logic [NUM_CH-1:0]       ch_l,
  input  logic [NUM_CH*CFG_W-1:0] trig_cfg,
  input  logic [QUAL_W-1:0]       qual_cnt,
  input  logic                    trig_clr,
  output logic                    trig_pulse,
  output logic                    triggered,
  output logic [1:0]              state_o
);

  state_t            state, state_nxt;
  logic              valid;
  logic              clr_hits;
  logic              pulse_nxt;
  logic [NUM_CH-1:0] ch_match;
  logic              all_match;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    trig_ch_slice u_slice (
      .clk        (clk),
      .rst        (rst),
      .armed      (armed),
      .valid      (valid),
      .clr        (clr_hits),
      .ch_h       (ch_h[i]),
      .ch_l       (ch_l[i]),
      .cfg        (trig_cfg[i*CFG_W +: CFG_W]),
      .ch_match_c (ch_match[i])
    );
  end

  assign all_match = &ch_match;

`ifdef MULTI_CHAN_TRIG_QUAL_EN
  logic [QUAL_W-1:0] qcnt, qcnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) qcnt <= '0;
    else     qcnt <= qcnt_nxt;
  end
`else
  logic unused_qual;
  assign unused_qual = ^qual_cnt;
`endif

  // State register with the registered pulse alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      valid      <= 1'b0;
      trig_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      valid      <= 1'b1;
      trig_pulse <= pulse_nxt;
    end
  end

  // Next state; disarm overrides everything else.
  always_comb begin
    state_nxt = state;
    clr_hits  = 1'b0;
`ifdef MULTI_CHAN_TRIG_QUAL_EN
    qcnt_nxt  = qcnt;
`endif
    if (!armed) begin
      state_nxt = ST_IDLE;
      clr_hits  = 1'b1;
`ifdef MULTI_CHAN_TRIG_QUAL_EN
      qcnt_nxt  = '0;
`endif
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_WAIT;
        ST_WAIT: begin
          if (all_match) begin
`ifdef MULTI_CHAN_TRIG_QUAL_EN
            if (qual_cnt != '0) begin
              state_nxt = ST_QUAL;
              qcnt_nxt  = QUAL_W'(1);
            end else begin
              state_nxt = ST_TRIG;
            end
`else
            state_nxt = ST_TRIG;
`endif
          end
        end
        ST_QUAL: begin
`ifdef MULTI_CHAN_TRIG_QUAL_EN
          // >= keeps a lowered qual_cnt from stranding the counter above it.
          if (!all_match) begin
            state_nxt = ST_WAIT;
            qcnt_nxt  = '0;
          end else if (qcnt >= qual_cnt) begin
            state_nxt = ST_TRIG;
          end else begin
            qcnt_nxt  = qcnt + QUAL_W'(1);
          end
`else
          state_nxt = ST_WAIT;
`endif
        end
        ST_TRIG: begin
          if (trig_clr) begin
            state_nxt = ST_WAIT;
            clr_hits  = 1'b1;
`ifdef MULTI_CHAN_TRIG_QUAL_EN
            qcnt_nxt  = '0;
`endif
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs decoded from the state flop and the next-state decision.
  always_comb begin
    pulse_nxt = (state_nxt == ST_TRIG) && (state != ST_TRIG);
    triggered = (state == ST_TRIG);
    state_o   = state;
  end

endmodule

// File: tb/tb_multi_chan_trig.sv
// Directed bench for multi_chan_trig: vector table plus multi-cycle sequences.
module tb_multi_chan_trig;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned QUAL_W = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic                armed;
  logic [NUM_CH-1:0]   ch_h;
  logic [NUM_CH-1:0]   ch_l;
  logic [NUM_CH*5-1:0] trig_cfg;
  logic [QUAL_W-1:0]   qual_cnt;
  logic                trig_clr;
  logic                trig_pulse;
  logic                triggered;
  logic [1:0]          state_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4:0] cfg;
    logic       h0, l0, h1, l1;
    logic       pre, pulse, trig;
  } vec_t;

  vec_t vecs [11];

  multi_chan_trig #(.NUM_CH(NUM_CH), .QUAL_W(QUAL_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .armed      (armed),
    .ch_h       (ch_h),
    .ch_l       (ch_l),
    .trig_cfg   (trig_cfg),
    .qual_cnt   (qual_cnt),
    .trig_clr   (trig_clr),
    .trig_pulse (trig_pulse),
    .triggered  (triggered),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    armed    = 1'b0;
    trig_clr = 1'b0;
    qual_cnt = '0;
    trig_cfg = {5'b00001, 5'b00001, 5'b00001, v.cfg};
    ch_h     = {3'b000, v.h0};
    ch_l     = {3'b000, v.l0};
    repeat (4) tick();
    armed = 1'b1;
    repeat (4) tick();
    check($sformatf("vec%0d_pre", idx), 32'(triggered), 32'(v.pre));
    ch_h[0] = v.h1;
    ch_l[0] = v.l1;
    tick();
    check($sformatf("vec%0d_k1", idx), 32'(trig_pulse), 32'(1'b0));
    tick();
    check($sformatf("vec%0d_k2", idx), 32'(trig_pulse), 32'(1'b0));
    tick();
    check($sformatf("vec%0d_pulse", idx), 32'(trig_pulse), 32'(v.pulse));
    check($sformatf("vec%0d_trig", idx), 32'(triggered), 32'(v.trig));
    tick();
    check($sformatf("vec%0d_after", idx), 32'(trig_pulse), 32'(1'b0));
    check($sformatf("vec%0d_hold", idx), 32'(triggered), 32'(v.trig));
  endtask

  // Drive a posedge trigger on ch0 and land in TRIG.
  task automatic arm_edge_trig(input string name);
    armed    = 1'b0;
    trig_clr = 1'b0;
    qual_cnt = '0;
    trig_cfg = {5'b00001, 5'b00001, 5'b00001, 5'b10000};
    ch_h     = '0;
    ch_l     = '0;
    repeat (4) tick();
    armed = 1'b1;
    repeat (4) tick();
    ch_h[0] = 1'b1;
    repeat (3) tick();
    check({name, "_reach_trig"}, 32'(triggered), 32'(1'b1));
  endtask

  initial begin
    //            cfg       h0    l0    h1    l1    pre   pulse trig
    vecs[0]  = '{5'b10000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{5'b10000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{5'b01000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{5'b01000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{5'b00100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{5'b00100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{5'b00010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{5'b00010, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{5'b00000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{5'b00001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{5'b11000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    rst      = 1'b1;
    armed    = 1'b0;
    ch_h     = '0;
    ch_l     = '0;
    trig_cfg = '0;
    qual_cnt = '0;
    trig_clr = 1'b0;
    repeat (3) tick();
    check("rst_pulse", 32'(trig_pulse), 32'(1'b0));
    check("rst_triggered", 32'(triggered), 32'(1'b0));
    check("rst_state", 32'(state_o), 32'(2'd0));
    rst = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Channel 1 low-level match gates the AND.
    armed    = 1'b0;
    trig_cfg = {5'b00001, 5'b00001, 5'b00010, 5'b00001};
    ch_h     = '0;
    ch_l     = 4'b0010;
    repeat (4) tick();
    armed = 1'b1;
    repeat (6) tick();
    check("ch1_lvl_hold", 32'(triggered), 32'(1'b0));
    ch_l[1] = 1'b0;
    repeat (2) tick();
    check("ch1_lvl_early", 32'(trig_pulse), 32'(1'b0));
    tick();
    check("ch1_lvl_pulse", 32'(trig_pulse), 32'(1'b1));

    // Disarm in TRIG, then re-arm with ch_h still high.
    arm_edge_trig("disarm");
    armed = 1'b0;
    tick();
    check("disarm_state", 32'(state_o), 32'(2'd0));
    check("disarm_triggered", 32'(triggered), 32'(1'b0));
    check("disarm_pulse", 32'(trig_pulse), 32'(1'b0));
    armed = 1'b1;
    repeat (6) tick();
    check("rearm_no_false_edge", 32'(triggered), 32'(1'b0));
    check("rearm_state_wait", 32'(state_o), 32'(2'd1));

    // trig_clr together with disarm goes to IDLE.
    arm_edge_trig("clr_disarm");
    trig_clr = 1'b1;
    armed    = 1'b0;
    tick();
    check("clr_disarm_state", 32'(state_o), 32'(2'd0));
    trig_clr = 1'b0;

    // trig_clr alone re-arms and needs a fresh edge.
    arm_edge_trig("clr");
    trig_clr = 1'b1;
    tick();
    trig_clr = 1'b0;
    check("clr_state_wait", 32'(state_o), 32'(2'd1));
    check("clr_triggered", 32'(triggered), 32'(1'b0));
    repeat (5) tick();
    check("clr_sticky_gone", 32'(triggered), 32'(1'b0));
    trig_clr = 1'b1;
    tick();
    trig_clr = 1'b0;
    check("clr_ignored_wait", 32'(state_o), 32'(2'd1));
    ch_h[0] = 1'b0;
    repeat (2) tick();
    ch_h[0] = 1'b1;
    repeat (2) tick();
    check("clr_retrig_early", 32'(trig_pulse), 32'(1'b0));
    tick();
    check("clr_retrig_pulse", 32'(trig_pulse), 32'(1'b1));

    // Reset while in TRIG with ch_h held high.
    arm_edge_trig("rst_trig");
    rst = 1'b1;
    tick();
    check("rst_trig_pulse", 32'(trig_pulse), 32'(1'b0));
    check("rst_trig_triggered", 32'(triggered), 32'(1'b0));
    check("rst_trig_state", 32'(state_o), 32'(2'd0));
    rst = 1'b0;
    repeat (6) tick();
    check("rst_no_false_edge", 32'(triggered), 32'(1'b0));
    ch_h[0] = 1'b0;
    repeat (2) tick();
    ch_h[0] = 1'b1;
    repeat (3) tick();
    check("rst_fresh_edge", 32'(trig_pulse), 32'(1'b1));

    // Qualification on a ch0 high level.
    armed    = 1'b0;
    trig_cfg = {5'b00001, 5'b00001, 5'b00001, 5'b00100};
    ch_h     = '0;
    ch_l     = '0;
    qual_cnt = 8'd3;
    repeat (4) tick();
    armed = 1'b1;
    repeat (4) tick();
`ifdef MULTI_CHAN_TRIG_QUAL_EN
    ch_h[0] = 1'b1;
    repeat (3) tick();
    check("qual_in_qual", 32'(state_o), 32'(2'd2));
    ch_h[0] = 1'b0;
    repeat (4) tick();
    check("qual_short_run", 32'(triggered), 32'(1'b0));
    check("qual_back_wait", 32'(state_o), 32'(2'd1));
    ch_h[0] = 1'b1;
    repeat (4) tick();
    ch_h[0] = 1'b0;
    tick();
    check("qual_run2_early", 32'(trig_pulse), 32'(1'b0));
    check("qual_run2_state", 32'(state_o), 32'(2'd2));
    tick();
    check("qual_run2_pulse", 32'(trig_pulse), 32'(1'b1));
    trig_clr = 1'b1;
    tick();
    trig_clr = 1'b0;
    ch_h[0] = 1'b1;
    repeat (3) tick();
    check("qual_disarm_pre", 32'(state_o), 32'(2'd2));
    armed = 1'b0;
    tick();
    check("qual_disarm_state", 32'(state_o), 32'(2'd0));
    check("qual_disarm_pulse", 32'(trig_pulse), 32'(1'b0));
    check("qual_disarm_triggered", 32'(triggered), 32'(1'b0));

    // Maximum qualification count is reachable.
    ch_h[0]  = 1'b0;
    qual_cnt = 8'hFF;
    repeat (4) tick();
    armed = 1'b1;
    repeat (4) tick();
    ch_h[0] = 1'b1;
    repeat (257) tick();
    check("qual_max_early", 32'(trig_pulse), 32'(1'b0));
    tick();
    check("qual_max_pulse", 32'(trig_pulse), 32'(1'b1));
`else
    ch_h[0] = 1'b1;
    repeat (2) tick();
    check("noqual_early", 32'(trig_pulse), 32'(1'b0));
    tick();
    check("noqual_pulse", 32'(trig_pulse), 32'(1'b1));
    check("noqual_state", 32'(state_o), 32'(2'd3));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
